// File: rtl/link_mem_bridge_pkg.sv
// Shared types and constants for the CPU-link target bridge.
package link_pkg;

    localparam int unsigned BEAT_W     = 2;
    localparam int unsigned LINK_BEATS = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    // Cycles from link_start to the earliest next link_start (no drain).
    function automatic int unsigned frame_len(input int unsigned wait_cyc);
        return 8 + wait_cyc;
    endfunction

endpackage

// File: rtl/link_mem_bridge_if.sv
// Link pins and memory-fabric handshake seen by link_mem_bridge.
interface link_mem_bridge_if;

    logic        link_start;
    logic        link_rw;
    logic [7:0]  link_addr_byte;
    logic [7:0]  link_wdata_byte;
    logic [7:0]  link_rdata_byte;
    logic        link_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err_timeout;
    logic        err_proto;

    // Bridge side.
    modport slave (
        input  link_start, link_rw, link_addr_byte, link_wdata_byte,
        input  mem_ack, mem_rdata,
        output link_rdata_byte, link_oe,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, err_timeout, err_proto
    );

    // CPU-handler and memory side.
    modport master (
        output link_start, link_rw, link_addr_byte, link_wdata_byte,
        output mem_ack, mem_rdata,
        input  link_rdata_byte, link_oe,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, err_timeout, err_proto
    );

endinterface

// File: rtl/link_mem_bridge_shift32.sv
// 32-bit register with byte-lane capture and an LSB-first byte serializer.
module link_shift32
    import link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [BEAT_W-1:0] cap_idx,
    input  logic [7:0]        cap_byte,
    input  logic              load,
    input  logic [31:0]       load_word,
    input  logic              shift,
    output logic [31:0]       word
);

    // Shifting zero-fills, so four shifts leave the register cleared and the
    // serial byte (word[7:0]) returns to 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (load) begin
            word <= load_word;
        end else if (shift) begin
            word <= {8'h00, word[31:8]};
        end else if (cap_en) begin
            word[{cap_idx, 3'b000} +: 8] <= cap_byte;
        end
    end

endmodule

// File: rtl/link_mem_bridge.sv
// Target-side CPU-link stage: 4-beat frame capture, one 32-bit memory request,
// fixed-window 4-beat read response.
module link_mem_bridge
    import link_pkg::*;
#(
    parameter int unsigned WAIT_CYC     = 2,
    parameter logic [31:0] TIMEOUT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    link_mem_bridge_if.slave  bus
);

    localparam int unsigned       WAIT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINK_BEATS - 1);

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              link_oe_q;
    logic              busy_q;
    logic              err_timeout_q;
    logic              err_proto_q;
    logic [31:0]       rdata_q;

    logic              start_ok;
    logic              cap_en;
    logic              ack_now;
    logic              deadline;
    logic [31:0]       resp_next;
    logic [31:0]       addr_word;
    logic [31:0]       wdata_word;
    logic [31:0]       resp_word;
    logic              unused_resp_bits;

    assign start_ok = bus.link_start && (state == IDLE);
    assign cap_en   = start_ok || (state == ADDR);
    assign ack_now  = mem_req_q && bus.mem_ack;
    assign deadline = (state == WAIT) && (wait_cnt == WAIT_LAST);

    // A request still pending at the deadline edge either completes right now
    // or has timed out; an earlier ack left its data in rdata_q.
    always_comb begin
        resp_next = rdata_q;
        if (mem_we_q) begin
            resp_next = '0;
        end else if (mem_req_q) begin
            resp_next = bus.mem_ack ? bus.mem_rdata : TIMEOUT_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            wait_cnt      <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            link_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
            rdata_q       <= '0;
        end else begin
            if (bus.link_start && busy_q) begin
                err_proto_q <= 1'b1;
            end
            if (ack_now) begin
                mem_req_q <= 1'b0;
                if (state == WAIT) begin
                    rdata_q <= bus.mem_rdata;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.link_start) begin
                        state    <= ADDR;
                        beat     <= BEAT_W'(1);
                        busy_q   <= 1'b1;
                        mem_we_q <= bus.link_rw;
                    end
                end
                ADDR: begin
                    beat <= beat + 1'b1;
                    if (beat == BEAT_LAST) begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        mem_req_q <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (deadline) begin
                        state     <= RESP;
                        beat      <= '0;
                        link_oe_q <= !mem_we_q;
                        if (mem_req_q && !bus.mem_ack) begin
                            err_timeout_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    beat <= beat + 1'b1;
                    if (beat == BEAT_LAST) begin
                        link_oe_q <= 1'b0;
                        if (mem_req_q && !bus.mem_ack) begin
                            state <= DRAIN;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.mem_ack) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    link_shift32 u_addr_cap (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .cap_idx   (beat),
        .cap_byte  (bus.link_addr_byte),
        .load      (1'b0),
        .load_word ('0),
        .shift     (1'b0),
        .word      (addr_word)
    );

    link_shift32 u_wdata_cap (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .cap_idx   (beat),
        .cap_byte  (bus.link_wdata_byte),
        .load      (1'b0),
        .load_word ('0),
        .shift     (1'b0),
        .word      (wdata_word)
    );

    link_shift32 u_resp_ser (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (1'b0),
        .cap_idx   ('0),
        .cap_byte  ('0),
        .load      (deadline),
        .load_word (resp_next),
        .shift     (state == RESP),
        .word      (resp_word)
    );

    assign unused_resp_bits = ^resp_word[31:8];

    assign bus.link_rdata_byte = resp_word[7:0];
    assign bus.link_oe         = link_oe_q;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = addr_word;
    assign bus.mem_wdata       = wdata_word;
    assign bus.busy            = busy_q;
    assign bus.err_timeout     = err_timeout_q;
    assign bus.err_proto       = err_proto_q;

endmodule

// File: tb/tb_link_mem_bridge.sv
// Directed bench for link_mem_bridge with WAIT_CYC=2; cycle k counts from link_start (c0).
module tb_link_mem_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    link_mem_bridge_if bus ();

    link_mem_bridge #(
        .WAIT_CYC     (2),
        .TIMEOUT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.link_start      = 1'b0;
        bus.link_rw         = 1'b0;
        bus.link_addr_byte  = 8'h00;
        bus.link_wdata_byte = 8'h00;
        bus.mem_ack         = 1'b0;
        bus.mem_rdata       = 32'hA5A5_5A5A;
    endtask

    // Drive link pins for cycle k; link_rw is inverted outside A0 to expose wrong sampling.
    task automatic drive_link(input int k, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic start);
        bus.link_start = start;
        bus.link_rw    = (k == 0) ? rw : ~rw;
        if (k < 4) begin
            bus.link_addr_byte  = addr[8*k +: 8];
            bus.link_wdata_byte = wdata[8*k +: 8];
        end else begin
            bus.link_addr_byte  = 8'h00;
            bus.link_wdata_byte = 8'h00;
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " mem_req"},     32'(bus.mem_req),         32'h0);
        chk({name, " busy"},        32'(bus.busy),            32'h0);
        chk({name, " link_oe"},     32'(bus.link_oe),         32'h0);
        chk({name, " rdata_byte"},  32'(bus.link_rdata_byte), 32'h0);
        chk({name, " mem_addr"},    bus.mem_addr,             32'h0);
        chk({name, " mem_wdata"},   bus.mem_wdata,            32'h0);
        chk({name, " mem_we"},      32'(bus.mem_we),          32'h0);
        chk({name, " err_timeout"}, 32'(bus.err_timeout),     32'h0);
        chk({name, " err_proto"},   32'(bus.err_proto),       32'h0);
    endtask

    // One full frame from c0; ack in cycle ack_k; extra link_start in cycle proto_k.
    task automatic run_frame(input string name, input logic rw, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_k,
                             input logic [31:0] rdata, input logic [31:0] exp_word,
                             input int proto_k);
        int   last;
        logic exp_oe;
        logic [7:0] exp_byte;
        last = (ack_k > 9) ? ack_k : 9;
        for (int k = 0; k <= last; k++) begin
            drive_link(k, rw, addr, wdata, (k == 0) || (k == proto_k));
            bus.mem_ack   = (k == ack_k);
            bus.mem_rdata = (k == ack_k) ? rdata : 32'hA5A5_5A5A;
            exp_oe   = !rw && (k >= 6) && (k <= 9);
            exp_byte = 8'h00;
            if (exp_oe) exp_byte = exp_word[8*(k-6) +: 8];
            chk($sformatf("%s k=%0d link_oe", name, k),    32'(bus.link_oe),         32'(exp_oe));
            chk($sformatf("%s k=%0d rdata_byte", name, k), 32'(bus.link_rdata_byte), 32'(exp_byte));
            chk($sformatf("%s k=%0d mem_req", name, k),    32'(bus.mem_req),
                32'((k >= 4) && (k <= ack_k)));
            chk($sformatf("%s k=%0d busy", name, k),       32'(bus.busy),
                32'((k >= 1) && (k <= last)));
            if (k == 4) begin
                chk({name, " mem_addr"},  bus.mem_addr,     addr);
                chk({name, " mem_wdata"}, bus.mem_wdata,    wdata);
                chk({name, " mem_we"},    32'(bus.mem_we),  32'(rw));
            end
            tick;
        end
        idle_inputs;
    endtask

    initial begin
        idle_inputs;
        rst = 1'b1;
        tick;
        tick;
        check_all_zero("reset");
        rst = 1'b0;

        // Read, zero-wait ack.
        run_frame("rd0", 1'b0, 32'h0000_0040, 32'h0000_0000, 4,
                  32'h1122_3344, 32'h1122_3344, -1);
        // Write: no read bytes driven.
        run_frame("wr", 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 4,
                  32'h0BAD_0BAD, 32'h0000_0000, -1);
        // Ack exactly at the deadline.
        run_frame("rd_dl", 1'b0, 32'h0000_0100, 32'h0000_0000, 5,
                  32'hCAFE_F00D, 32'hCAFE_F00D, -1);
        chk("after rd_dl err_timeout", 32'(bus.err_timeout), 32'h0);
        chk("after rd_dl err_proto",   32'(bus.err_proto),   32'h0);

        // Ack long after the deadline: timeout word, DRAIN until cycle 12.
        run_frame("rd_to", 1'b0, 32'h0000_0200, 32'h0000_0000, 12,
                  32'h5566_7788, 32'hFFFF_FFFF, -1);
        chk("after rd_to err_timeout", 32'(bus.err_timeout), 32'h1);
        chk("after rd_to err_proto",   32'(bus.err_proto),   32'h0);

        // Stray link_start mid-frame.
        run_frame("rd_pr", 1'b0, 32'h00AB_0300, 32'h0000_0000, 4,
                  32'h0102_0304, 32'h0102_0304, 2);
        chk("after rd_pr err_proto",   32'(bus.err_proto),   32'h1);
        chk("after rd_pr err_timeout", 32'(bus.err_timeout), 32'h1);

        // Reset in cycle c0+5 with the request outstanding.
        for (int k = 0; k <= 5; k++) begin
            drive_link(k, 1'b0, 32'h0000_0400, 32'h0000_0000, k == 0);
            if (k >= 4) chk($sformatf("rst_frame k=%0d mem_req", k), 32'(bus.mem_req), 32'h1);
            if (k == 5) rst = 1'b1;
            tick;
        end
        rst = 1'b0;
        idle_inputs;
        check_all_zero("mid_reset");

        // Back-to-back reads at c0 and c0+10 with zero-wait memory.
        run_frame("b2b0", 1'b0, 32'h0000_0500, 32'h0000_0000, 4,
                  32'hA1B2_C3D4, 32'hA1B2_C3D4, -1);
        run_frame("b2b1", 1'b0, 32'h0000_0504, 32'h0000_0000, 4,
                  32'h0F1E_2D3C, 32'h0F1E_2D3C, -1);
        chk("final busy",        32'(bus.busy),            32'h0);
        chk("final link_oe",     32'(bus.link_oe),         32'h0);
        chk("final rdata_byte",  32'(bus.link_rdata_byte), 32'h0);
        chk("final err_timeout", 32'(bus.err_timeout),     32'h0);
        chk("final err_proto",   32'(bus.err_proto),       32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
